// File: rtl/mips_bus_wait_injector_pkg.sv
// Shared types and constants for the bus wait-state injector.
package mips_bus_pkg;

  localparam int LFSR_W  = 16;
  localparam int STALL_W = 4;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    ISSUE,
    RESP
  } bus_inj_state_t;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/mips_bus_wait_injector_if.sv
// Avalon-MM bus bundle; one instance on the CPU side, one on the memory side.
interface mips_bus_wait_injector_if;

  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata
  );

endinterface

// File: rtl/mips_bus_wait_injector_lfsr.sv
// 16-bit Galois LFSR that steps only when asked to.
module mips_bus_lfsr
  import mips_bus_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  output logic [LFSR_W-1:0] state
);

  // Hold the sequence until a transaction is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SEED;
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/mips_bus_wait_injector.sv
// Pass-through Avalon-MM stage that holds every CPU transfer for a
// programmable number of wait states before forwarding it to memory.
module mips_bus_wait_injector
  import mips_bus_pkg::*;
#(
  parameter int                STALL_MODE  = 0,
  parameter int                FIXED_STALL = 2,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      reset,
  mips_bus_wait_injector_if.slave   m,
  mips_bus_wait_injector_if.master  s,
  output logic                      protocol_error,
  output logic [15:0]               txn_count
);

  localparam logic [STALL_W-1:0] FIXED_N = STALL_W'(FIXED_STALL);

  bus_inj_state_t     state;
  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_n;
  logic [LFSR_W-1:0]  lfsr_state;
  logic               request;
  logic               accept;

  logic [31:0] lat_address;
  logic [3:0]  lat_byteenable;
  logic [31:0] lat_writedata;
  logic        lat_write;

  logic        wait_r;
  logic [31:0] rdata_r;
  logic [31:0] s_address_r;
  logic        s_read_r;
  logic        s_write_r;
  logic [3:0]  s_byteenable_r;
  logic [31:0] s_writedata_r;

  assign request = m.read | m.write;
  assign accept  = (state == IDLE) && request;
  assign stall_n = (STALL_MODE == 1) ? lfsr_state[STALL_W-1:0] : FIXED_N;

  mips_bus_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (accept),
    .state   (lfsr_state)
  );

  // Capture the accepted request; write wins when both strobes are high.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_address    <= m.address;
      lat_byteenable <= m.byteenable;
      lat_writedata  <= m.writedata;
      lat_write      <= m.write;
    end
  end

  // Transaction FSM with registered bus outputs, counters and error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      stall_cnt      <= '0;
      wait_r         <= 1'b1;
      rdata_r        <= '0;
      s_address_r    <= '0;
      s_read_r       <= 1'b0;
      s_write_r      <= 1'b0;
      s_byteenable_r <= '0;
      s_writedata_r  <= '0;
      txn_count      <= '0;
      protocol_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            if (m.read && m.write) begin
              protocol_error <= 1'b1;
            end
            stall_cnt <= stall_n;
            if (stall_n != '0) begin
              state <= STALL;
            end else begin
              // Zero stall: the latches are not valid yet, so forward directly.
              state          <= ISSUE;
              s_address_r    <= m.address;
              s_read_r       <= ~m.write;
              s_write_r      <= m.write;
              s_byteenable_r <= m.byteenable;
              s_writedata_r  <= m.writedata;
            end
          end
        end
        STALL: begin
          stall_cnt <= stall_cnt - 1'b1;
          if (stall_cnt == STALL_W'(1)) begin
            state          <= ISSUE;
            s_address_r    <= lat_address;
            s_read_r       <= ~lat_write;
            s_write_r      <= lat_write;
            s_byteenable_r <= lat_byteenable;
            s_writedata_r  <= lat_writedata;
          end
        end
        ISSUE: begin
          if (!s.waitrequest) begin
            if (!lat_write) begin
              rdata_r <= s.readdata;
            end
            s_address_r    <= '0;
            s_read_r       <= 1'b0;
            s_write_r      <= 1'b0;
            s_byteenable_r <= '0;
            s_writedata_r  <= '0;
            wait_r         <= 1'b0;
            txn_count      <= txn_count + 16'd1;
            state          <= RESP;
          end
        end
        RESP: begin
          wait_r <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          wait_r <= 1'b1;
        end
      endcase
    end
  end

  assign m.waitrequest = wait_r;
  assign m.readdata    = rdata_r;
  assign s.address     = s_address_r;
  assign s.read        = s_read_r;
  assign s.write       = s_write_r;
  assign s.byteenable  = s_byteenable_r;
  assign s.writedata   = s_writedata_r;

endmodule

// File: tb/tb_mips_bus_wait_injector.sv
// Directed bench for the wait-state injector: four instances cover the
// fixed-stall settings 2, 0 and 1 and the LFSR mode, each with its own
// small memory model that can hold waitrequest for a set number of cycles.
module tb_mips_bus_wait_injector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic        rst_n     [4];
  logic [31:0] c_addr    [4];
  logic        c_read    [4];
  logic        c_write   [4];
  logic [3:0]  c_be      [4];
  logic [31:0] c_wdata   [4];
  int          mem_wait  [4];

  logic        m_wait    [4];
  logic [31:0] m_rdata   [4];
  logic        s_rd      [4];
  logic        s_wr      [4];
  logic [31:0] s_addr    [4];
  logic [3:0]  s_be      [4];
  logic [31:0] s_wd      [4];
  logic        perr      [4];
  logic [15:0] txn       [4];

  for (genvar g = 0; g < 4; g++) begin : inst
    mips_bus_wait_injector_if cpu ();
    mips_bus_wait_injector_if mem ();
    logic [31:0] words [16];
    int          wcnt;

    assign cpu.address    = c_addr[g];
    assign cpu.read       = c_read[g];
    assign cpu.write      = c_write[g];
    assign cpu.byteenable = c_be[g];
    assign cpu.writedata  = c_wdata[g];
    assign m_wait[g]      = cpu.waitrequest;
    assign m_rdata[g]     = cpu.readdata;
    assign s_rd[g]        = mem.read;
    assign s_wr[g]        = mem.write;
    assign s_addr[g]      = mem.address;
    assign s_be[g]        = mem.byteenable;
    assign s_wd[g]        = mem.writedata;

    assign mem.waitrequest = (mem.read | mem.write) && (wcnt < mem_wait[g]);
    assign mem.readdata    = words[mem.address[5:2]];

    mips_bus_wait_injector #(
      .STALL_MODE  ((g == 3) ? 1 : 0),
      .FIXED_STALL ((g == 0) ? 2 : (g == 2) ? 1 : 0),
      .LFSR_SEED   (16'hACE1)
    ) dut (
      .clk            (clk),
      .reset          (rst_n[g]),
      .m              (cpu),
      .s              (mem),
      .protocol_error (perr[g]),
      .txn_count      (txn[g])
    );

    initial begin
      wcnt = 0;
      for (int i = 0; i < 16; i++) begin
        if (g == 1)
          words[i] = 32'h0;
        else if (g == 0 && i == 0)
          words[i] = 32'h12345678;
        else
          words[i] = {16'hA5A5, 12'h000, 4'(i)};
      end
    end

    always @(posedge clk) begin
      if (!(mem.read | mem.write)) begin
        wcnt <= 0;
      end else if (wcnt < mem_wait[g]) begin
        wcnt <= wcnt + 1;
      end else begin
        wcnt <= 0;
        if (mem.write) begin
          for (int b = 0; b < 4; b++)
            if (mem.byteenable[b])
              words[mem.address[5:2]][8*b +: 8] <= mem.writedata[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Run one CPU transfer on instance g; lat counts cycles from acceptance to
  // the cycle in which waitrequest is low.
  task automatic do_txn(input int g, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata,
                        output int rd_cyc, output int wr_cyc,
                        output bit stable, output logic [3:0] obs_be,
                        output logic [31:0] obs_wd);
    logic [31:0] first_addr;
    bit          seen;
    bit          done;
    lat = 0; rd_cyc = 0; wr_cyc = 0; stable = 1'b1; seen = 1'b0; done = 1'b0;
    obs_be = '0; obs_wd = '0; first_addr = '0; rdata = '0;
    @(negedge clk);
    c_addr[g] = addr; c_read[g] = rd; c_write[g] = wr; c_be[g] = be; c_wdata[g] = wd;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      lat++;
      if (s_rd[g]) rd_cyc++;
      if (s_wr[g]) wr_cyc++;
      if (s_rd[g] | s_wr[g]) begin
        if (!seen) begin
          seen = 1'b1; first_addr = s_addr[g]; obs_be = s_be[g]; obs_wd = s_wd[g];
        end else if (s_addr[g] !== first_addr || s_be[g] !== obs_be) begin
          stable = 1'b0;
        end
      end
      if (m_wait[g] === 1'b0) begin
        rdata = m_rdata[g];
        done = 1'b1;
        break;
      end
    end
    chk("txn_completed", 32'(done), 32'd1);
    c_read[g] = 1'b0; c_write[g] = 1'b0;
  endtask

  int          lat, rc, wc;
  bit          st;
  logic [31:0] rd;
  logic [3:0]  obe;
  logic [31:0] owd;
  logic [15:0] lf;
  logic [3:0]  n_exp;

  initial begin
    for (int g = 0; g < 4; g++) begin
      rst_n[g] = 1'b0; c_addr[g] = '0; c_read[g] = 1'b0; c_write[g] = 1'b0;
      c_be[g] = '0; c_wdata[g] = '0; mem_wait[g] = (g == 2) ? 3 : 0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk("rst_waitrequest", 32'(m_wait[g]), 32'd1);
      chk("rst_s_read", 32'(s_rd[g]), 32'd0);
    end
    for (int g = 0; g < 4; g++) rst_n[g] = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk("idle_waitrequest", 32'(m_wait[g]), 32'd1);
      chk("idle_txn_count", 32'(txn[g]), 32'd0);
      chk("idle_protocol_error", 32'(perr[g]), 32'd0);
      chk("idle_readdata", m_rdata[g], 32'd0);
    end

    // Fixed stall of 2, zero-wait memory.
    do_txn(0, 1'b1, 1'b0, 32'hBFC00000, 4'hF, 32'h0, lat, rd, rc, wc, st, obe, owd);
    chk("t1_latency", 32'(lat), 32'd4);
    chk("t1_s_read_cycles", 32'(rc), 32'd1);
    chk("t1_readdata", rd, 32'h12345678);
    chk("t1_txn_count", 32'(txn[0]), 32'd1);
    @(negedge clk);
    chk("t1_wait_back_high", 32'(m_wait[0]), 32'd1);

    // No stall: partial write then readback.
    do_txn(1, 1'b0, 1'b1, 32'h00001000, 4'b0011, 32'hDEADBEEF, lat, rd, rc, wc, st, obe, owd);
    chk("t2_wr_latency", 32'(lat), 32'd2);
    chk("t2_s_write_cycles", 32'(wc), 32'd1);
    chk("t2_s_byteenable", 32'(obe), 32'h3);
    chk("t2_s_writedata", owd, 32'hDEADBEEF);
    chk("t2_readdata_held", rd, 32'h0);
    do_txn(1, 1'b1, 1'b0, 32'h00001000, 4'hF, 32'h0, lat, rd, rc, wc, st, obe, owd);
    chk("t2_rd_latency", 32'(lat), 32'd2);
    chk("t2_readback", rd, 32'h0000BEEF);
    chk("t2_txn_count", 32'(txn[1]), 32'd2);

    // Memory holds waitrequest for 3 cycles, fixed stall of 1.
    do_txn(2, 1'b1, 1'b0, 32'h00000008, 4'b0110, 32'h0, lat, rd, rc, wc, st, obe, owd);
    chk("t3_s_read_cycles", 32'(rc), 32'd4);
    chk("t3_bus_stable", 32'(st), 32'd1);
    chk("t3_s_byteenable", 32'(obe), 32'h6);
    chk("t3_latency", 32'(lat), 32'd6);
    chk("t3_readdata", rd, 32'hA5A50002);

    // LFSR mode: 20 reads with reference stall counts.
    lf = 16'hACE1;
    for (int i = 0; i < 20; i++) begin
      n_exp = lf[3:0];
      lf = ref_lfsr(lf);
      do_txn(3, 1'b1, 1'b0, 32'(((i % 16) * 4)), 4'hF, 32'h0, lat, rd, rc, wc, st, obe, owd);
      chk($sformatf("t4_latency_%0d", i), 32'(lat), 32'(n_exp) + 32'd2);
      chk($sformatf("t4_readdata_%0d", i), rd, {16'hA5A5, 12'h000, 4'(i % 16)});
      chk($sformatf("t4_s_read_cycles_%0d", i), 32'(rc), 32'd1);
    end
    chk("t4_txn_count", 32'(txn[3]), 32'd20);

    // Read and write together: only the write goes out, flag is sticky.
    do_txn(1, 1'b1, 1'b1, 32'h00001004, 4'hF, 32'hCAFEF00D, lat, rd, rc, wc, st, obe, owd);
    chk("t5_s_read_cycles", 32'(rc), 32'd0);
    chk("t5_s_write_cycles", 32'(wc), 32'd1);
    chk("t5_protocol_error", 32'(perr[1]), 32'd1);
    do_txn(1, 1'b1, 1'b0, 32'h00001004, 4'hF, 32'h0, lat, rd, rc, wc, st, obe, owd);
    chk("t5_readback", rd, 32'hCAFEF00D);
    chk("t5_error_sticky", 32'(perr[1]), 32'd1);

    // Asynchronous reset while the transfer is in ISSUE.
    @(negedge clk);
    c_addr[0] = 32'hBFC00000; c_read[0] = 1'b1; c_be[0] = 4'hF;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (s_rd[0]) break;
    end
    chk("t6_reached_issue", 32'(s_rd[0]), 32'd1);
    #1 rst_n[0] = 1'b0;
    #1;
    chk("t6_s_read_dropped", 32'(s_rd[0]), 32'd0);
    chk("t6_s_write_low", 32'(s_wr[0]), 32'd0);
    chk("t6_waitrequest", 32'(m_wait[0]), 32'd1);
    chk("t6_txn_count", 32'(txn[0]), 32'd0);
    c_read[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    do_txn(0, 1'b1, 1'b0, 32'hBFC00000, 4'hF, 32'h0, lat, rd, rc, wc, st, obe, owd);
    chk("t6_after_latency", 32'(lat), 32'd4);
    chk("t6_after_readdata", rd, 32'h12345678);
    chk("t6_after_txn_count", 32'(txn[0]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
